// File: rtl/imem_loader.sv
// imem_loader: parses framed UART byte images into little-endian IMEM words,
// holding the CPU in reset while a load is in progress or after a failed load.
module imem_loader #(
    parameter int          NUM_WORDS_IMEM = 8192,
    parameter logic [29:0] BASE_WADDR     = 30'h0,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int          TIMEOUT_CYC    = 1000000
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        rx_vld,
    input  logic [7:0]  rx_dat,
    output logic        imem_cpu_rstn,
    output logic        imem_we,
    output logic [29:0] imem_waddr,
    output logic [31:0] imem_wdat,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [15:0] words_loaded
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CSUM} state_t;

    state_t      state, state_nxt;
    logic [15:0] len, word_idx, n_len;
    logic [1:0]  byte_idx, fail_code;
    logic [23:0] wbuf;
    logic [7:0]  acc;
    logic [TW-1:0] tmo_cnt;
    logic        fail, ok, tmo_hit, start;

    assign n_len   = {rx_dat, len[7:0]};
    assign start   = state == IDLE && rx_vld && rx_dat == SYNC_BYTE;
    assign tmo_hit = state != IDLE && !rx_vld && tmo_cnt == TW'(TIMEOUT_CYC - 1);

    // An arriving byte always wins over a coincident timeout expiry.
    always_comb begin
        state_nxt = state;
        fail      = 1'b0;
        fail_code = 2'd0;
        ok        = 1'b0;
        if (tmo_hit) begin
            fail      = 1'b1;
            fail_code = 2'd2;
            state_nxt = IDLE;
        end else if (rx_vld) begin
            case (state)
                IDLE: state_nxt = rx_dat == SYNC_BYTE ? LEN0 : IDLE;
                LEN0: state_nxt = LEN1;
                LEN1: begin
                    fail      = 32'(n_len) > 32'(NUM_WORDS_IMEM);
                    fail_code = fail ? 2'd1 : 2'd0;
                    state_nxt = fail ? IDLE : (n_len == 16'd0 ? CSUM : DATA);
                end
                DATA: state_nxt = (byte_idx == 2'd3 && word_idx == len - 16'd1) ? CSUM : DATA;
                CSUM: begin
                    ok        = rx_dat == acc;
                    fail      = !ok;
                    fail_code = ok ? 2'd0 : 2'd3;
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state         <= IDLE;
            imem_cpu_rstn <= 1'b1;
            imem_we       <= 1'b0;
            imem_waddr    <= BASE_WADDR;
            imem_wdat     <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            err_code      <= 2'd0;
            words_loaded  <= '0;
            len           <= '0;
            word_idx      <= '0;
            byte_idx      <= '0;
            wbuf          <= '0;
            acc           <= '0;
            tmo_cnt       <= '0;
        end else begin
            state   <= state_nxt;
            imem_we <= 1'b0;
            done    <= 1'b0;
            tmo_cnt <= (state == IDLE || rx_vld) ? '0 : tmo_cnt + 1'b1;
            if (start) begin
                imem_cpu_rstn <= 1'b0;
                busy          <= 1'b1;
                err           <= 1'b0;
                err_code      <= 2'd0;
                byte_idx      <= '0;
                word_idx      <= '0;
                acc           <= '0;
            end
            if (rx_vld && state == LEN0) len[7:0] <= rx_dat;
            if (rx_vld && state == LEN1) len[15:8] <= rx_dat;
            if (rx_vld && state == DATA) begin
                wbuf     <= {rx_dat, wbuf[23:8]};
                acc      <= acc ^ rx_dat;
                byte_idx <= byte_idx + 2'd1;
                if (byte_idx == 2'd3) begin
                    imem_we    <= 1'b1;
                    imem_wdat  <= {rx_dat, wbuf};
                    imem_waddr <= BASE_WADDR + 30'(word_idx);
                    word_idx   <= word_idx + 16'd1;
                end
            end
            if (fail) begin
                err      <= 1'b1;
                err_code <= fail_code;
                busy     <= 1'b0;
            end
            if (ok) begin
                done          <= 1'b1;
                words_loaded  <= len;
                imem_cpu_rstn <= 1'b1;
                busy          <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed frames against imem_loader with a 100-cycle timeout;
// IMEM writes and done pulses are logged on the falling edge.
module tb_imem_loader;
    logic        clk = 1'b0;
    logic        arst_n, rx_vld;
    logic [7:0]  rx_dat;
    logic        imem_cpu_rstn, imem_we, busy, done, err;
    logic [29:0] imem_waddr;
    logic [31:0] imem_wdat;
    logic [1:0]  err_code;
    logic [15:0] words_loaded;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_cnt   = 0;
    int done_cnt = 0;
    logic [29:0] wr_addr [0:7];
    logic [31:0] wr_data [0:7];

    imem_loader #(.TIMEOUT_CYC(100)) dut (
        .clk(clk), .arst_n(arst_n), .rx_vld(rx_vld), .rx_dat(rx_dat),
        .imem_cpu_rstn(imem_cpu_rstn), .imem_we(imem_we), .imem_waddr(imem_waddr),
        .imem_wdat(imem_wdat), .busy(busy), .done(done), .err(err),
        .err_code(err_code), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we) begin
            if (wr_cnt < 8) begin
                wr_addr[wr_cnt] = imem_waddr;
                wr_data[wr_cnt] = imem_wdat;
            end
            wr_cnt = wr_cnt + 1;
        end
        if (done) done_cnt = done_cnt + 1;
    end

    task automatic send(input logic [7:0] b);
        rx_vld = 1'b1;
        rx_dat = b;
        @(posedge clk); #1;
        rx_vld = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_good;
        send(8'hA5); send(8'h02); send(8'h00);
        send(8'h13); send(8'h00); send(8'h00); send(8'h00);
        send(8'h6F); send(8'h00); send(8'h00); send(8'h00);
        send(8'h7C);
    endtask

    task automatic test_reset;
        arst_n = 1'b0; rx_vld = 1'b0; rx_dat = 8'h00;
        idle(3);
        n_checks++; if (imem_cpu_rstn !== 1'b1) begin n_fail++; $display("FAIL reset_cpu_rstn got %b want 1", imem_cpu_rstn); end
        n_checks++; if (imem_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b want 0", imem_we); end
        n_checks++; if (imem_waddr !== 30'h0) begin n_fail++; $display("FAIL reset_waddr got %h want 0", imem_waddr); end
        n_checks++; if (imem_wdat !== 32'h0) begin n_fail++; $display("FAIL reset_wdat got %h want 0", imem_wdat); end
        n_checks++; if ({busy, done, err, err_code} !== 5'b0) begin n_fail++; $display("FAIL reset_status got %b want 00000", {busy, done, err, err_code}); end
        n_checks++; if (words_loaded !== 16'h0) begin n_fail++; $display("FAIL reset_words got %h want 0", words_loaded); end
        arst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_nominal;
        wr_cnt = 0; done_cnt = 0;
        send(8'hA5);
        n_checks++; if (imem_cpu_rstn !== 1'b0) begin n_fail++; $display("FAIL nom_hold_cpu got %b want 0", imem_cpu_rstn); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL nom_busy got %b want 1", busy); end
        send(8'h02); send(8'h00);
        send(8'h13); send(8'h00); send(8'h00); send(8'h00);
        send(8'h6F); send(8'h00); send(8'h00); send(8'h00);
        send(8'h7C);
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL nom_done got %b want 1", done); end
        n_checks++; if (imem_cpu_rstn !== 1'b1) begin n_fail++; $display("FAIL nom_release got %b want 1", imem_cpu_rstn); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL nom_busy_end got %b want 0", busy); end
        n_checks++; if (words_loaded !== 16'd2) begin n_fail++; $display("FAIL nom_words got %0d want 2", words_loaded); end
        idle(4);
        n_checks++; if (wr_cnt !== 2) begin n_fail++; $display("FAIL nom_wr_cnt got %0d want 2", wr_cnt); end
        n_checks++; if (wr_addr[0] !== 30'd0 || wr_data[0] !== 32'h00000013) begin n_fail++; $display("FAIL nom_wr0 got %h/%h want 0/00000013", wr_addr[0], wr_data[0]); end
        n_checks++; if (wr_addr[1] !== 30'd1 || wr_data[1] !== 32'h0000006F) begin n_fail++; $display("FAIL nom_wr1 got %h/%h want 1/0000006f", wr_addr[1], wr_data[1]); end
        n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL nom_done_cnt got %0d want 1", done_cnt); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL nom_err got %b want 0", err); end
    endtask

    task automatic test_bad_csum;
        wr_cnt = 0; done_cnt = 0;
        send(8'hA5); send(8'h02); send(8'h00);
        send(8'h13); send(8'h00); send(8'h00); send(8'h00);
        send(8'h6F); send(8'h00); send(8'h00); send(8'h00);
        send(8'h7D);
        n_checks++; if (err !== 1'b1 || err_code !== 2'd3) begin n_fail++; $display("FAIL csum_err got %b/%0d want 1/3", err, err_code); end
        n_checks++; if (imem_cpu_rstn !== 1'b0) begin n_fail++; $display("FAIL csum_hold got %b want 0", imem_cpu_rstn); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL csum_busy got %b want 0", busy); end
        idle(3);
        n_checks++; if (wr_cnt !== 2 || done_cnt !== 0) begin n_fail++; $display("FAIL csum_writes got wr=%0d done=%0d want wr=2 done=0", wr_cnt, done_cnt); end
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL csum_sticky got %b want 1", err); end
        send(8'hA5);
        n_checks++; if (err !== 1'b0 || err_code !== 2'd0) begin n_fail++; $display("FAIL csum_clear got %b/%0d want 0/0", err, err_code); end
        send(8'h02); send(8'h00);
        send(8'h13); send(8'h00); send(8'h00); send(8'h00);
        send(8'h6F); send(8'h00); send(8'h00); send(8'h00);
        send(8'h7C);
        n_checks++; if (imem_cpu_rstn !== 1'b1 || done !== 1'b1) begin n_fail++; $display("FAIL csum_recover got rstn=%b done=%b want 1/1", imem_cpu_rstn, done); end
        idle(2);
    endtask

    task automatic test_oversize;
        wr_cnt = 0;
        send(8'hA5); send(8'h01); send(8'h20);
        n_checks++; if (err !== 1'b1 || err_code !== 2'd1) begin n_fail++; $display("FAIL over_err got %b/%0d want 1/1", err, err_code); end
        n_checks++; if (busy !== 1'b0 || imem_cpu_rstn !== 1'b0) begin n_fail++; $display("FAIL over_status got busy=%b rstn=%b want 0/0", busy, imem_cpu_rstn); end
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        idle(3);
        n_checks++; if (wr_cnt !== 0) begin n_fail++; $display("FAIL over_wr_cnt got %0d want 0", wr_cnt); end
    endtask

    task automatic test_timeout;
        send(8'hA5); send(8'h01); send(8'h00); send(8'h11);
        idle(99);
        n_checks++; if (err !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL tmo_early got err=%b busy=%b want 0/1", err, busy); end
        idle(1);
        n_checks++; if (err !== 1'b1 || err_code !== 2'd2) begin n_fail++; $display("FAIL tmo_err got %b/%0d want 1/2", err, err_code); end
        n_checks++; if (busy !== 1'b0 || imem_cpu_rstn !== 1'b0) begin n_fail++; $display("FAIL tmo_status got busy=%b rstn=%b want 0/0", busy, imem_cpu_rstn); end
    endtask

    task automatic test_zero_garbage;
        wr_cnt = 0; done_cnt = 0;
        send(8'h00); send(8'hFF);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_garbage_busy got %b want 0", busy); end
        send(8'hA5); send(8'h00); send(8'h00); send(8'h00);
        n_checks++; if (done !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL zero_done got done=%b err=%b want 1/0", done, err); end
        n_checks++; if (words_loaded !== 16'd0 || imem_cpu_rstn !== 1'b1) begin n_fail++; $display("FAIL zero_words got %0d rstn=%b want 0/1", words_loaded, imem_cpu_rstn); end
        idle(3);
        n_checks++; if (wr_cnt !== 0 || done_cnt !== 1) begin n_fail++; $display("FAIL zero_counts got wr=%0d done=%0d want 0/1", wr_cnt, done_cnt); end
    endtask

    task automatic test_reset_mid;
        wr_cnt = 0;
        send(8'hA5); send(8'h02); send(8'h00);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04); send(8'h05); send(8'h06);
        arst_n = 1'b0;
        idle(1);
        n_checks++; if (imem_cpu_rstn !== 1'b1 || busy !== 1'b0 || imem_we !== 1'b0) begin n_fail++; $display("FAIL mid_reset got rstn=%b busy=%b we=%b want 1/0/0", imem_cpu_rstn, busy, imem_we); end
        n_checks++; if (imem_waddr !== 30'd0 || imem_wdat !== 32'd0 || words_loaded !== 16'd0) begin n_fail++; $display("FAIL mid_reset_regs got %h/%h/%h want 0/0/0", imem_waddr, imem_wdat, words_loaded); end
        n_checks++; if (wr_cnt !== 1 || wr_data[0] !== 32'h04030201) begin n_fail++; $display("FAIL mid_first_word got cnt=%0d data=%h want 1/04030201", wr_cnt, wr_data[0]); end
        arst_n = 1'b1;
        wr_cnt = 0;
        send(8'h07); send(8'h08);
        idle(3);
        n_checks++; if (wr_cnt !== 0) begin n_fail++; $display("FAIL mid_no_write got %0d want 0", wr_cnt); end
        send_good();
        idle(3);
        n_checks++; if (wr_cnt !== 2 || wr_data[1] !== 32'h0000006F || words_loaded !== 16'd2) begin n_fail++; $display("FAIL mid_reload got cnt=%0d data=%h words=%0d want 2/0000006f/2", wr_cnt, wr_data[1], words_loaded); end
    endtask

    initial begin
        arst_n = 1'b0; rx_vld = 1'b0; rx_dat = 8'h00;
        @(posedge clk); #1;
        test_reset();
        test_nominal();
        test_bad_csum();
        test_oversize();
        test_timeout();
        test_zero_garbage();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
